// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: standard field ranges and
// BCD <-> decimal helpers used by the BCD counters.
package clock_pkg;

    // Standard field ranges (decimal, inclusive).
    localparam int HOUR24_MIN = 0;
    localparam int HOUR24_MAX = 23;
    localparam int HOUR12_MIN = 1;
    localparam int HOUR12_MAX = 12;
    localparam int MINSEC_MIN = 0;
    localparam int MINSEC_MAX = 59;

    // Two BCD digits, tens first.
    typedef struct packed {
        logic [3:0] h;
        logic [3:0] l;
    } bcd_t;

    // Decimal value 10*h + l, computed at 7 bits.
    function automatic logic [6:0] bcd2dec(input logic [3:0] h, input logic [3:0] l);
        logic [6:0] h7;
        h7 = 7'(h);
        return (h7 * 7'd10) + 7'(l);
    endfunction

    // Constant conversion of a decimal value (0..99) to two BCD digits.
    function automatic bcd_t dec2bcd(input int v);
        bcd_t r;
        r.h = 4'(v / 10);
        r.l = 4'(v % 10);
        return r;
    endfunction

    // Inclusive range test on a 7-bit decimal value.
    function automatic logic in_range(input logic [6:0] v, input logic [6:0] lo,
                                      input logic [6:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Both digits are legal BCD codes.
    function automatic logic digits_ok(input logic [3:0] h, input logic [3:0] l);
        return (h <= 4'd9) && (l <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single mod-(TOP+1) BCD digit with load, up and down stepping. Wraps
// TOP->0 on up and 0->TOP on down; at_max_o/at_min_o flag the wrap points
// so the enclosing field can ripple into the next digit.
module bcd_digit #(
    parameter int           W       = 4,
    parameter int           TOP     = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] q_o,
    output logic         at_max_o,
    output logic         at_min_o
);

    localparam logic [W-1:0] TOP_Q = W'(TOP);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign q_o      = q_q;
    assign at_max_o = (q_q == TOP_Q);
    assign at_min_o = (q_q == '0);

    // Next digit value: load wins over up, up over down.
    always_comb begin
        // NOTE: assign the default first so every path drives q_d and no latch is inferred.
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (inc_i) begin
            q_d = at_max_o ? '0 : q_q + W'(1);
        end else if (dec_i) begin
            q_d = at_min_o ? TOP_Q : q_q - W'(1);
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter MIN_VAL..MAX_VAL with up/down count, checked
// parallel load and registered CARRY/BORROW/LDERR pulses for cascading.
// Define BCD_MOD_COUNTER_MATCH_EN to add the CMPH/CMPL compare inputs and
// the registered MATCH output used for alarm compare.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MIN_VAL = HOUR24_MIN,
    parameter int MAX_VAL = HOUR24_MAX,
    parameter int HW      = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          INC,
    input  logic          DEC,
    input  logic          LD,
    input  logic [HW-1:0] LDH,
    input  logic [3:0]    LDL,
    output logic [HW-1:0] QH,
    output logic [3:0]    QL,
    output logic          CARRY,
    output logic          BORROW,
    output logic          LDERR
`ifdef BCD_MOD_COUNTER_MATCH_EN
   ,input  logic [HW-1:0] CMPH,
    input  logic [3:0]    CMPL,
    output logic          MATCH
`endif
);

    localparam bcd_t          MIN_BCD = dec2bcd(MIN_VAL);
    localparam bcd_t          MAX_BCD = dec2bcd(MAX_VAL);
    localparam logic [HW-1:0] MIN_H   = HW'(MIN_BCD.h);
    localparam logic [3:0]    MIN_L   = MIN_BCD.l;
    localparam logic [HW-1:0] MAX_H   = HW'(MAX_BCD.h);
    localparam logic [3:0]    MAX_L   = MAX_BCD.l;
    localparam logic [6:0]    MIN7    = 7'(MIN_VAL);
    localparam logic [6:0]    MAX7    = 7'(MAX_VAL);
    // Tens digit never needs to wrap on its own; field wrap is a load.
    localparam int            H_TOP   = (((1 << HW) - 1) < 9) ? ((1 << HW) - 1) : 9;

    logic [6:0]    val;
    logic          legal;
    logic          ld_ok;
    logic          dig_ld;
    logic [HW-1:0] dig_ldh;
    logic [3:0]    dig_ldl;
    logic          l_inc, l_dec, h_inc, h_dec;
    logic          l_at_max, l_at_min;
    logic          h_at_max, h_at_min;
    logic          unused_h_flags;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;
    logic          lderr_q, lderr_d;

    assign val            = bcd2dec(4'(QH), QL);
    assign legal          = digits_ok(4'(QH), QL) && in_range(val, MIN7, MAX7);
    assign ld_ok          = digits_ok(4'(LDH), LDL) && in_range(bcd2dec(4'(LDH), LDL), MIN7, MAX7);
    assign unused_h_flags = h_at_max ^ h_at_min;

    // Field control: decode priority and turn field wraps into digit loads.
    always_comb begin
        dig_ld   = 1'b0;
        dig_ldh  = QH;
        dig_ldl  = QL;
        l_inc    = 1'b0;
        l_dec    = 1'b0;
        h_inc    = 1'b0;
        h_dec    = 1'b0;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        lderr_d  = 1'b0;
        if (CLR) begin
            dig_ld  = 1'b1;
            dig_ldh = MIN_H;
            dig_ldl = MIN_L;
        end else if (LD) begin
            if (ld_ok) begin
                dig_ld  = 1'b1;
                dig_ldh = LDH;
                dig_ldl = LDL;
            end else begin
                lderr_d = 1'b1;
            end
        end else if (INC && !DEC) begin
            if (!legal || (val == MAX7)) begin
                // Wrap to MIN; an illegal encoding recovers without a pulse.
                dig_ld  = 1'b1;
                dig_ldh = MIN_H;
                dig_ldl = MIN_L;
                carry_d = legal;
            end else begin
                l_inc = 1'b1;
                h_inc = l_at_max;
            end
        end else if (DEC && !INC) begin
            if (!legal) begin
                dig_ld  = 1'b1;
                dig_ldh = MIN_H;
                dig_ldl = MIN_L;
            end else if (val == MIN7) begin
                dig_ld   = 1'b1;
                dig_ldh  = MAX_H;
                dig_ldl  = MAX_L;
                borrow_d = 1'b1;
            end else begin
                l_dec = 1'b1;
                h_dec = l_at_min;
            end
        end
    end

    bcd_digit #(
        .W       (4),
        .TOP     (9),
        .RST_VAL (MIN_L)
    ) u_ones (
        .clk_i    (CLK),
        .rst_i    (RST),
        .ld_i     (dig_ld),
        .ld_val_i (dig_ldl),
        .inc_i    (l_inc),
        .dec_i    (l_dec),
        .q_o      (QL),
        .at_max_o (l_at_max),
        .at_min_o (l_at_min)
    );

    bcd_digit #(
        .W       (HW),
        .TOP     (H_TOP),
        .RST_VAL (MIN_H)
    ) u_tens (
        .clk_i    (CLK),
        .rst_i    (RST),
        .ld_i     (dig_ld),
        .ld_val_i (dig_ldh),
        .inc_i    (h_inc),
        .dec_i    (h_dec),
        .q_o      (QH),
        .at_max_o (h_at_max),
        .at_min_o (h_at_min)
    );

    // Pulse registers: one cycle, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            lderr_q  <= 1'b0;
        end else begin
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            lderr_q  <= lderr_d;
        end
    end

    assign CARRY  = carry_q;
    assign BORROW = borrow_q;
    assign LDERR  = lderr_q;

`ifdef BCD_MOD_COUNTER_MATCH_EN
    logic [6:0] nxt_val;
    logic       match_q;

    // Value the digits take at the next edge, so MATCH lines up with QH/QL.
    always_comb begin
        nxt_val = val;
        if (dig_ld) begin
            nxt_val = bcd2dec(4'(dig_ldh), dig_ldl);
        end else if (l_inc) begin
            nxt_val = val + 7'd1;
        end else if (l_dec) begin
            nxt_val = val - 7'd1;
        end
    end

    // Registered compare against the alarm value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (nxt_val == bcd2dec(4'(CMPH), CMPL));
        end
    end

    assign MATCH = match_q;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: three instances (0..23, 1..12, 0..59) driven
// from shared stimulus and checked every cycle against a decimal model.
module tb_bcd_mod_counter;
    import clock_pkg::*;

    localparam int MINS [3] = '{HOUR24_MIN, HOUR12_MIN, MINSEC_MIN};
    localparam int MAXS [3] = '{HOUR24_MAX, HOUR12_MAX, MINSEC_MAX};
    localparam int HWS  [3] = '{2, 1, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b0, clr = 1'b0, inc = 1'b0, dec = 1'b0, ld = 1'b0;
    logic [2:0] ldh = '0;
    logic [3:0] ldl = '0;
    logic [2:0] cmph = '0;
    logic [3:0] cmpl = '0;

    logic [1:0] qh0;
    logic [0:0] qh1;
    logic [2:0] qh2;
    logic [3:0] qh [3];
    logic [3:0] ql [3];
    logic       car [3];
    logic       bor [3];
    logic       lde [3];
`ifdef BCD_MOD_COUNTER_MATCH_EN
    logic       mat [3];
`endif

    int mval [3];
    int mc [3], mb [3], me [3], mm [3];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        qh[0] = 4'(qh0);
        qh[1] = 4'(qh1);
        qh[2] = 4'(qh2);
    end

    bcd_mod_counter #(.MIN_VAL(HOUR24_MIN), .MAX_VAL(HOUR24_MAX), .HW(2)) u_h24 (
        .CLK(clk), .RST(rst), .CLR(clr), .INC(inc), .DEC(dec), .LD(ld),
        .LDH(ldh[1:0]), .LDL(ldl), .QH(qh0), .QL(ql[0]),
        .CARRY(car[0]), .BORROW(bor[0]), .LDERR(lde[0])
`ifdef BCD_MOD_COUNTER_MATCH_EN
        , .CMPH(cmph[1:0]), .CMPL(cmpl), .MATCH(mat[0])
`endif
    );

    bcd_mod_counter #(.MIN_VAL(HOUR12_MIN), .MAX_VAL(HOUR12_MAX), .HW(1)) u_h12 (
        .CLK(clk), .RST(rst), .CLR(clr), .INC(inc), .DEC(dec), .LD(ld),
        .LDH(ldh[0:0]), .LDL(ldl), .QH(qh1), .QL(ql[1]),
        .CARRY(car[1]), .BORROW(bor[1]), .LDERR(lde[1])
`ifdef BCD_MOD_COUNTER_MATCH_EN
        , .CMPH(cmph[0:0]), .CMPL(cmpl), .MATCH(mat[1])
`endif
    );

    bcd_mod_counter #(.MIN_VAL(MINSEC_MIN), .MAX_VAL(MINSEC_MAX), .HW(3)) u_ms (
        .CLK(clk), .RST(rst), .CLR(clr), .INC(inc), .DEC(dec), .LD(ld),
        .LDH(ldh), .LDL(ldl), .QH(qh2), .QL(ql[2]),
        .CARRY(car[2]), .BORROW(bor[2]), .LDERR(lde[2])
`ifdef BCD_MOD_COUNTER_MATCH_EN
        , .CMPH(cmph), .CMPL(cmpl), .MATCH(mat[2])
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int dval(input int k);
        return 10 * int'(qh[k]) + int'(ql[k]);
    endfunction

    // Reference model: decimal arithmetic straight from the counting rules.
    task automatic model_step(input int k);
        int v, nv, hmask, lv;
        v     = mval[k];
        nv    = v;
        hmask = (1 << HWS[k]) - 1;
        mc[k] = 0;
        mb[k] = 0;
        me[k] = 0;
        if (rst || clr) begin
            nv = MINS[k];
        end else if (ld) begin
            lv = 10 * (int'(ldh) & hmask) + int'(ldl);
            if (ldl <= 9 && lv >= MINS[k] && lv <= MAXS[k]) nv = lv;
            else me[k] = 1;
        end else if (inc && !dec) begin
            if (v == MAXS[k]) begin nv = MINS[k]; mc[k] = 1; end
            else nv = v + 1;
        end else if (dec && !inc) begin
            if (v == MINS[k]) begin nv = MAXS[k]; mb[k] = 1; end
            else nv = v - 1;
        end
        mm[k]   = (!rst && nv == 10 * (int'(cmph) & hmask) + int'(cmpl)) ? 1 : 0;
        mval[k] = nv;
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_qh%0d", tag, k), 8'(qh[k]), 8'(mval[k] / 10));
            check($sformatf("%s_ql%0d", tag, k), 8'(ql[k]), 8'(mval[k] % 10));
            check($sformatf("%s_carry%0d", tag, k), 8'(car[k]), 8'(mc[k]));
            check($sformatf("%s_borrow%0d", tag, k), 8'(bor[k]), 8'(mb[k]));
            check($sformatf("%s_lderr%0d", tag, k), 8'(lde[k]), 8'(me[k]));
`ifdef BCD_MOD_COUNTER_MATCH_EN
            check($sformatf("%s_match%0d", tag, k), 8'(mat[k]), 8'(mm[k]));
`endif
        end
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic c, input logic l,
                        input logic i, input logic d, input int h, input int lo);
        rst = r; clr = c; ld = l; inc = i; dec = d;
        ldh = 3'(h); ldl = 4'(lo);
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        // Reset
        step("rst", 1, 0, 0, 0, 0, 0, 0);
        check("rst_h24", 8'(dval(0)), 8'd0);
        check("rst_h12", 8'(dval(1)), 8'd1);
        check("rst_pulse", 8'({car[0], bor[0], lde[0]}), 8'd0);

        // 1: 24 up-steps on 0..23, CARRY only on the 00 cycle
        for (int i = 1; i <= 24; i++) begin
            step("t1", 0, 0, 0, 1, 0, 0, 0);
            check("t1_val", 8'(dval(0)), 8'(i % 24));
            check("t1_carry", 8'(car[0]), 8'(i == 24));
        end

        // 2: down-count wrap and tens borrow
        step("t2_wrap", 0, 0, 0, 0, 1, 0, 0);
        check("t2_23", 8'(dval(0)), 8'd23);
        check("t2_borrow", 8'(bor[0]), 8'd1);
        step("t2_hold", 0, 0, 0, 0, 0, 0, 0);
        check("t2_borrow_off", 8'(bor[0]), 8'd0);
        step("t2_ld10", 0, 0, 1, 0, 0, 1, 0);
        step("t2_dec10", 0, 0, 0, 0, 1, 0, 0);
        check("t2_09", 8'(dval(0)), 8'd9);
        step("t2_ld20", 0, 0, 1, 0, 0, 2, 0);
        step("t2_dec20", 0, 0, 0, 0, 1, 0, 0);
        check("t2_19", 8'(dval(0)), 8'd19);

        // 3: 1..12 instance
        step("t3_rst", 1, 0, 0, 0, 0, 0, 0);
        check("t3_01", 8'(dval(1)), 8'd1);
        step("t3_ld12", 0, 0, 1, 0, 0, 1, 2);
        check("t3_12", 8'(dval(1)), 8'd12);
        step("t3_wrap", 0, 0, 0, 1, 0, 0, 0);
        check("t3_wrap01", 8'(dval(1)), 8'd1);
        check("t3_carry", 8'(car[1]), 8'd1);
        step("t3_ld00", 0, 0, 1, 0, 0, 0, 0);
        check("t3_lderr00", 8'(lde[1]), 8'd1);
        check("t3_keep", 8'(dval(1)), 8'd1);
        step("t3_ld113", 0, 0, 1, 0, 0, 1, 13);
        check("t3_lderr113", 8'(lde[1]), 8'd1);

        // 4: 0..59 instance, HW=3
        step("t4_ld59", 0, 0, 1, 1, 0, 5, 9);
        check("t4_59", 8'(dval(2)), 8'd59);
        check("t4_nocarry", 8'(car[2]), 8'd0);
        step("t4_wrap", 0, 0, 0, 1, 0, 0, 0);
        check("t4_00", 8'(dval(2)), 8'd0);
        check("t4_carry", 8'(car[2]), 8'd1);
        step("t4_ld310", 0, 0, 1, 0, 0, 3, 10);
        check("t4_lderr", 8'(lde[2]), 8'd1);

        // 5: priority
        step("t5_ld17", 0, 0, 1, 0, 0, 1, 7);
        step("t5_clr", 0, 1, 1, 1, 0, 1, 7);
        check("t5_clr_h24", 8'(dval(0)), 8'd0);
        check("t5_clr_h12", 8'(dval(1)), 8'd1);
        check("t5_clr_pulse", 8'({car[1], lde[1], car[0]}), 8'd0);
        step("t5_ld17b", 0, 0, 1, 0, 0, 1, 7);
        step("t5_incdec", 0, 0, 0, 1, 1, 0, 0);
        check("t5_hold17", 8'(dval(0)), 8'd17);
        step("t5_rstinc", 1, 0, 0, 1, 0, 0, 0);
        check("t5_rst_h24", 8'(dval(0)), 8'd0);
        check("t5_rst_pulse", 8'({car[0], bor[0], lde[0]}), 8'd0);

`ifdef BCD_MOD_COUNTER_MATCH_EN
        // 6: alarm compare at 07
        cmph = 3'd0;
        cmpl = 4'd7;
        step("t6_ld05", 0, 0, 1, 0, 0, 0, 5);
        for (int j = 0; j < 4; j++) begin
            step("t6_inc", 0, 0, 0, 1, 0, 0, 0);
            check("t6_match", 8'(mat[0]), 8'(j == 1));
        end
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) begin
                cmph = 3'($urandom_range(0, 5));
                cmpl = 4'($urandom_range(0, 9));
            end
            step("rnd",
                 logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 24) == 0),
                 logic'($urandom_range(0, 4) == 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 9)));
            for (int k = 0; k < 3; k++)
                check("rnd_excl", 8'(car[k] & bor[k]), 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
